// File: rtl/bf16_div.sv
// BF16 divider: restoring mantissa division (1 bit/cycle) with fixed 12-edge latency.
// Define BF16_DIV_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module bf16_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] flp_a,
    input  logic [15:0] flp_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quot,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t             state_q;
    special_t           special_q, special_d;
    logic [3:0]         cnt_q;
    logic               sign_q;
    logic [7:0]         mb_q;
    logic [9:0]         rem_q, rem_d;
    logic [9:0]         q_q;
    logic signed [9:0]  expd_q, expd_d;
    logic [15:0]        quot_q, norm_d;
    logic               outv_q;
    logic               ge;

    logic [7:0] ea, eb;
    logic       a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    // Operand classification; exponent field 0 counts as zero (no denormal support).
    always_comb begin
        ea      = flp_a[14:7];
        eb      = flp_b[14:7];
        a_zero  = (ea == 8'h00);
        b_zero  = (eb == 8'h00);
        a_inf   = (ea == 8'hFF) && (flp_a[6:0] == 7'h0);
        b_inf   = (eb == 8'hFF) && (flp_b[6:0] == 7'h0);
        a_nan   = (ea == 8'hFF) && (flp_a[6:0] != 7'h0);
        b_nan   = (eb == 8'hFF) && (flp_b[6:0] != 7'h0);
        expd_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            special_d = SP_NAN;
        else if (b_zero || a_inf)
            special_d = SP_INF;
        else if (a_zero || b_inf)
            special_d = SP_ZERO;
        else
            special_d = SP_NONE;
    end

    // One restoring step; the partial remainder is pre-shifted for the next bit.
    always_comb begin
        ge    = (rem_q >= {2'b00, mb_q});
        rem_d = ge ? (rem_q - {2'b00, mb_q}) : rem_q;
        rem_d = {rem_d[8:0], 1'b0};
    end

    logic [6:0]        frac;
    logic signed [9:0] e;
`ifdef BF16_DIV_RNE_EN
    logic       guard, sticky;
    logic [7:0] rnd;
`endif

    always_comb begin
        if (q_q[9]) begin
            frac = q_q[8:2];
            e    = expd_q;
        end else begin
            frac = q_q[7:1];
            e    = expd_q - 10'sd1;
        end
`ifdef BF16_DIV_RNE_EN
        guard  = q_q[9] ? q_q[1] : q_q[0];
        sticky = (q_q[9] & q_q[0]) | (rem_q != 10'd0);
        rnd    = {1'b0, frac} + {7'b0, guard & (sticky | frac[0])};
        frac   = rnd[6:0];
        if (rnd[7])
            e = e + 10'sd1;
`endif
        if (e >= 10'sd255)
            norm_d = {sign_q, 8'hFF, 7'h00};
        else if (e <= 10'sd0)
            norm_d = {sign_q, 15'h0000};
        else
            norm_d = {sign_q, e[7:0], frac};
        case (special_q)
            SP_NAN:  norm_d = 16'h7FC0;
            SP_INF:  norm_d = {sign_q, 8'hFF, 7'h00};
            SP_ZERO: norm_d = {sign_q, 15'h0000};
            default: ;
        endcase
    end

    // Control FSM; out_valid rises one cycle after DONE is entered to give 12-edge latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            outv_q    <= 1'b0;
            quot_q    <= 16'h0000;
            sign_q    <= 1'b0;
            mb_q      <= 8'h00;
            rem_q     <= 10'd0;
            q_q       <= 10'd0;
            expd_q    <= 10'sd0;
            special_q <= SP_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q    <= flp_a[15] ^ flp_b[15];
                        mb_q      <= {1'b1, flp_b[6:0]};
                        rem_q     <= {3'b001, flp_a[6:0]};
                        q_q       <= 10'd0;
                        expd_q    <= expd_d;
                        special_q <= special_d;
                        cnt_q     <= 4'd9;
                        state_q   <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    q_q   <= {q_q[8:0], ge};
                    if (cnt_q == 4'd0)
                        state_q <= NORM;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                NORM: begin
                    quot_q  <= norm_d;
                    state_q <= DONE;
                end
                DONE: begin
                    if (!outv_q) begin
                        outv_q <= 1'b1;
                    end else if (out_ready) begin
                        outv_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = outv_q;
    assign quot      = quot_q;

endmodule

// File: tb/tb_bf16_div.sv
// Self-checking bench for bf16_div: vector table plus handshake, hold and reset sequences.
module tb_bf16_div;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] flp_a, flp_b, quot;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
    } vec_t;

    vec_t vecs[16];

    bf16_div dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flp_a(flp_a), .flp_b(flp_b), .out_valid(out_valid),
        .out_ready(out_ready), .quot(quot), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Runs one operation with out_ready low until the result shows, then hands it off.
    task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] expq);
        int lat;
        @(negedge clk);
        flp_a = a; flp_b = b; in_valid = 1'b1;
        checkOutput({name, " in_ready"}, {15'b0, in_ready}, 16'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        checkOutput({name, " latency"}, 16'(lat), 16'd12);
        checkOutput({name, " quot"}, quot, expq);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        checkOutput({name, " in_ready after"}, {15'b0, in_ready}, 16'd1);
    endtask

    initial begin
        vecs[0]  = '{"6/2",       16'h40C0, 16'h4000, 16'h4040};
        vecs[1]  = '{"-1.5/0.5",  16'hBFC0, 16'h3F00, 16'hC040};
        vecs[2]  = '{"1/1",       16'h3F80, 16'h3F80, 16'h3F80};
        vecs[3]  = '{"1/2",       16'h3F80, 16'h4000, 16'h3F00};
`ifdef BF16_DIV_RNE_EN
        vecs[4]  = '{"1/3",       16'h3F80, 16'h4040, 16'h3EAB};
`else
        vecs[4]  = '{"1/3",       16'h3F80, 16'h4040, 16'h3EAA};
`endif
        vecs[5]  = '{"1/0",       16'h3F80, 16'h0000, 16'h7F80};
        vecs[6]  = '{"0/0",       16'h0000, 16'h0000, 16'h7FC0};
        vecs[7]  = '{"overflow",  16'h7F7F, 16'h0080, 16'h7F80};
        vecs[8]  = '{"underflow", 16'h0080, 16'h7F00, 16'h0000};
        vecs[9]  = '{"-underflow",16'h8080, 16'h7F00, 16'h8000};
        vecs[10] = '{"nan/1",     16'h7FC1, 16'h3F80, 16'h7FC0};
        vecs[11] = '{"inf/inf",   16'h7F80, 16'hFF80, 16'h7FC0};
        vecs[12] = '{"-inf/2",    16'hFF80, 16'h4000, 16'hFF80};
        vecs[13] = '{"2/-inf",    16'h4000, 16'hFF80, 16'h8000};
        vecs[14] = '{"denorm/1",  16'h0001, 16'h3F80, 16'h0000};
        vecs[15] = '{"-1/0",      16'hBF80, 16'h0000, 16'hFF80};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flp_a = 16'h0; flp_b = 16'h0;
        #12;
        checkOutput("reset out_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("reset quot", quot, 16'h0000);
        checkOutput("reset busy", {15'b0, busy}, 16'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 16; i++)
            applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q);

        // Result held for 5 cycles with a second request that must be ignored.
        @(negedge clk);
        flp_a = 16'h3F80; flp_b = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        checkOutput("hold busy", {15'b0, busy}, 16'd1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("hold out_valid", {15'b0, out_valid}, 16'd1);
        checkOutput("hold quot", quot, 16'h3F00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            flp_a = 16'h40C0; flp_b = 16'h4000;
            @(posedge clk); #1;
            checkOutput("held quot", quot, 16'h3F00);
            checkOutput("held out_valid", {15'b0, out_valid}, 16'd1);
            checkOutput("held in_ready", {15'b0, in_ready}, 16'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        checkOutput("release in_ready", {15'b0, in_ready}, 16'd1);
        checkOutput("release out_valid", {15'b0, out_valid}, 16'd0);
        repeat (3) @(posedge clk);
        #1 checkOutput("ignored request busy", {15'b0, busy}, 16'd0);

        // out_ready high before DONE: exactly one out_valid cycle.
        begin
            int lat;
            out_ready = 1'b1;
            @(negedge clk);
            flp_a = 16'h40C0; flp_b = 16'h4000; in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
            checkOutput("early ready latency", 16'(lat), 16'd12);
            checkOutput("early ready quot", quot, 16'h4040);
            @(posedge clk); #1;
            checkOutput("early ready out_valid", {15'b0, out_valid}, 16'd0);
            checkOutput("early ready in_ready", {15'b0, in_ready}, 16'd1);
            out_ready = 1'b0;
        end

        // Reset during the 4th DIV cycle, with a nonzero quotient still held.
        applyStimulus("pre-reset -1/0", 16'hBF80, 16'h0000, 16'hFF80);
        @(negedge clk);
        flp_a = 16'h40C0; flp_b = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid reset out_valid", {15'b0, out_valid}, 16'd0);
        checkOutput("mid reset quot", quot, 16'h0000);
        checkOutput("mid reset busy", {15'b0, busy}, 16'd0);
        @(negedge clk) rst = 1'b0;
        #1 checkOutput("post reset in_ready", {15'b0, in_ready}, 16'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 15; k++) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1'b1;
            end
            checkOutput("discarded result", {15'b0, seen}, 16'd0);
        end
        applyStimulus("post reset 6/2", 16'h40C0, 16'h4000, 16'h4040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
